// File: rtl/cv32e40p_pkg.sv
// rtl/cv32e40p_pkg.sv - shared ALU fault-tolerance types, class constants and operator-to-class mapping
package cv32e40p_pkg;

  localparam int unsigned N_ALU_CLASS = 9;
  localparam int unsigned N_FT_ALU    = 4;

  localparam logic [3:0] ALU_CLASS_SHIFT_ADD = 4'd0;
  localparam logic [3:0] ALU_CLASS_LOGIC     = 4'd1;
  localparam logic [3:0] ALU_CLASS_BITMAN    = 4'd2;
  localparam logic [3:0] ALU_CLASS_BITCNT    = 4'd3;
  localparam logic [3:0] ALU_CLASS_SHUFFLE   = 4'd4;
  localparam logic [3:0] ALU_CLASS_COMPARE   = 4'd5;
  localparam logic [3:0] ALU_CLASS_ABS_CLIP  = 4'd6;
  localparam logic [3:0] ALU_CLASS_MINMAX    = 4'd7;
  localparam logic [3:0] ALU_CLASS_DIV_REM   = 4'd8;
  localparam logic [3:0] ALU_CLASS_INVALID   = 4'd15;

  typedef enum logic [1:0] {
    NONE   = 2'b00,
    SINGLE = 2'b01,
    DMR    = 2'b10,
    TMR    = 2'b11
  } vote_mode_e;

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } sched_state_e;

  // One allocation table entry: voter mode, ALU routed to each voter input, executing ALUs
  typedef struct packed {
    vote_mode_e       mode;
    logic [2:0][1:0]  sel;
    logic [3:0]       enable;
  } alloc_entry_t;

  typedef enum logic [6:0] {
    ALU_ADD   = 7'b0011000,
    ALU_SUB   = 7'b0011001,
    ALU_SRA   = 7'b0100100,
    ALU_SRL   = 7'b0100101,
    ALU_SLL   = 7'b0100111,
    ALU_XOR   = 7'b0101111,
    ALU_OR    = 7'b0101110,
    ALU_AND   = 7'b0010101,
    ALU_BEXT  = 7'b0101000,
    ALU_BINS  = 7'b0101010,
    ALU_BCLR  = 7'b0101011,
    ALU_BSET  = 7'b0101100,
    ALU_FF1   = 7'b0110110,
    ALU_FL1   = 7'b0110111,
    ALU_CNT   = 7'b0110100,
    ALU_CLB   = 7'b0110101,
    ALU_SHUF  = 7'b0111010,
    ALU_SHUF2 = 7'b0111011,
    ALU_LTS   = 7'b0000000,
    ALU_LTU   = 7'b0000001,
    ALU_EQ    = 7'b0001100,
    ALU_NE    = 7'b0001101,
    ALU_ABS   = 7'b0010100,
    ALU_CLIP  = 7'b0010110,
    ALU_CLIPU = 7'b0010111,
    ALU_MIN   = 7'b0010000,
    ALU_MAX   = 7'b0010010,
    ALU_DIVU  = 7'b0110000,
    ALU_DIV   = 7'b0110001,
    ALU_REMU  = 7'b0110010,
    ALU_REM   = 7'b0110011
  } alu_opcode_e;

  // Maps an ALU operator onto the operation class whose allocation entry it uses
  function automatic logic [3:0] alu_class_f(input alu_opcode_e op);
    logic [3:0] cls;
    cls = ALU_CLASS_INVALID;
    case (op)
      ALU_ADD, ALU_SUB, ALU_SRA, ALU_SRL, ALU_SLL:    cls = ALU_CLASS_SHIFT_ADD;
      ALU_XOR, ALU_OR, ALU_AND:                       cls = ALU_CLASS_LOGIC;
      ALU_BEXT, ALU_BINS, ALU_BCLR, ALU_BSET:         cls = ALU_CLASS_BITMAN;
      ALU_FF1, ALU_FL1, ALU_CNT, ALU_CLB:             cls = ALU_CLASS_BITCNT;
      ALU_SHUF, ALU_SHUF2:                            cls = ALU_CLASS_SHUFFLE;
      ALU_LTS, ALU_LTU, ALU_EQ, ALU_NE:               cls = ALU_CLASS_COMPARE;
      ALU_ABS, ALU_CLIP, ALU_CLIPU:                   cls = ALU_CLASS_ABS_CLIP;
      ALU_MIN, ALU_MAX:                               cls = ALU_CLASS_MINMAX;
      ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM:           cls = ALU_CLASS_DIV_REM;
      default:                                        cls = ALU_CLASS_INVALID;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/cv32e40p_alu_tmr_scheduler_ft_if.sv
// rtl/cv32e40p_alu_tmr_scheduler_ft_if.sv - issue/allocation bus between ID/EX and the ALU scheduler
interface cv32e40p_alu_tmr_scheduler_ft_if;
  import cv32e40p_pkg::*;

  logic             op_valid_i;
  logic [3:0]       op_class_i;
  logic             stall_o;
  logic [3:0]       alu_enable_o;
  logic [2:0][1:0]  alu_sel_o;
  vote_mode_e       vote_mode_o;
  logic [3:0]       counter_clock_en_o;

  modport master (
    output op_valid_i, op_class_i,
    input  stall_o, alu_enable_o, alu_sel_o, vote_mode_o, counter_clock_en_o
  );

  modport slave (
    input  op_valid_i, op_class_i,
    output stall_o, alu_enable_o, alu_sel_o, vote_mode_o, counter_clock_en_o
  );

endinterface

// File: rtl/cv32e40p_alu_select_ft.sv
// rtl/cv32e40p_alu_select_ft.sv - healthy mask plus rotation offset to one allocation entry
module cv32e40p_alu_select_ft
  import cv32e40p_pkg::*;
(
  input  logic [3:0]    healthy_i,
  input  logic [1:0]    offset_i,
  output alloc_entry_t  entry_o
);

  // Scan ALUs from the offset, take the first three healthy ones, pad unused voter inputs with sel[0]
  always_comb begin
    logic [1:0] idx;
    logic [1:0] taken;
    entry_o = '0;
    idx     = 2'd0;
    taken   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      idx = offset_i + 2'(i);
      if (healthy_i[idx] && (taken != 2'd3)) begin
        case (taken)
          2'd0:    entry_o.sel[0] = idx;
          2'd1:    entry_o.sel[1] = idx;
          default: entry_o.sel[2] = idx;
        endcase
        entry_o.enable[idx] = 1'b1;
        taken = taken + 2'd1;
      end
    end
    if (taken < 2'd2) entry_o.sel[1] = entry_o.sel[0];
    if (taken < 2'd3) entry_o.sel[2] = entry_o.sel[0];
    entry_o.mode = vote_mode_e'(taken);
  end

endmodule

// File: rtl/cv32e40p_alu_tmr_scheduler_ft.sv
// rtl/cv32e40p_alu_tmr_scheduler_ft.sv - per-class ALU allocation table and voter mode scheduler (option: CV32E40P_ALU_SPARE_ROTATE_EN)
module cv32e40p_alu_tmr_scheduler_ft
  import cv32e40p_pkg::*;
#(
  parameter int unsigned N_CLASS       = N_ALU_CLASS,
  parameter int unsigned ROTATE_PERIOD = 256
)(
  input  logic                       clock_gated,
  input  logic                       rst_n,
  cv32e40p_alu_tmr_scheduler_ft_if.slave bus,
  input  logic [3:0][N_CLASS-1:0]    permanent_faulty_alu_i,
  output logic [N_CLASS-1:0]         degraded_o,
  output logic                       sched_error_o
);

  if ((ROTATE_PERIOD < 2) || (ROTATE_PERIOD > 256)) begin : g_bad_rotate_period
    $error("ROTATE_PERIOD must lie in 2..256 for the 8-bit op counter");
  end

  sched_state_e              state_q, state_d;
  logic [3:0]                k_q, k_d;
  logic [3:0][N_CLASS-1:0]   fault_q;
  alloc_entry_t              table_q [N_CLASS];
  logic [N_CLASS-1:0]        degraded_q;
  logic                      sched_err_q;

  logic                      fault_changed;
  logic                      sweep_we;
  logic                      rot_trigger;
  logic [1:0]                offset;
  logic [3:0]                healthy_k;
  alloc_entry_t              sweep_entry;
  alloc_entry_t              look_entry;
  logic                      class_ok;
  logic                      lookup_ok;

  assign fault_changed = (permanent_faulty_alu_i != fault_q);
  assign bus.stall_o   = (state_q != RUN) | fault_changed;
  assign class_ok      = (bus.op_class_i < 4'(N_CLASS));
  assign lookup_ok     = bus.op_valid_i & ~bus.stall_o & class_ok;
  assign degraded_o    = degraded_q;
  assign sched_error_o = sched_err_q;

  // Healthy mask of the class currently being swept
  always_comb begin
    healthy_k = '0;
    for (int a = 0; a < 4; a++) begin
      healthy_k[a] = ~permanent_faulty_alu_i[a][k_q];
    end
  end

  cv32e40p_alu_select_ft u_select (
    .healthy_i (healthy_k),
    .offset_i  (offset),
    .entry_o   (sweep_entry)
  );

  // Table read for the issued class; invalid classes never index the table
  always_comb begin
    look_entry = '0;
    if (class_ok) look_entry = table_q[bus.op_class_i];
  end

  // Drive the allocation for this cycle's operation, or all-zero when none is allowed
  always_comb begin
    bus.alu_enable_o       = '0;
    bus.alu_sel_o          = '0;
    bus.vote_mode_o        = NONE;
    bus.counter_clock_en_o = '0;
    if (lookup_ok) begin
      bus.alu_enable_o       = look_entry.enable;
      bus.alu_sel_o          = look_entry.sel;
      bus.vote_mode_o        = look_entry.mode;
      bus.counter_clock_en_o = look_entry.enable;
    end
  end

`ifdef CV32E40P_ALU_SPARE_ROTATE_EN
  logic [7:0] op_cnt_q, op_cnt_d;
  logic [1:0] offset_q, offset_d;
  logic       tmr_issue;

  assign tmr_issue = lookup_ok & (look_entry.mode == TMR);
  assign offset    = offset_q;

  // Count issued TMR ops; on wrap move the scan start so the previous spare gets used
  always_comb begin
    op_cnt_d    = op_cnt_q;
    offset_d    = offset_q;
    rot_trigger = 1'b0;
    if (tmr_issue) begin
      if (op_cnt_q == 8'(ROTATE_PERIOD - 1)) begin
        op_cnt_d    = 8'd0;
        offset_d    = offset_q + 2'd1;
        rot_trigger = 1'b1;
      end else begin
        op_cnt_d = op_cnt_q + 8'd1;
      end
    end
  end

  // Rotation counter and offset registers
  always_ff @(posedge clock_gated or negedge rst_n) begin
    if (!rst_n) begin
      op_cnt_q <= 8'd0;
      offset_q <= 2'd0;
    end else begin
      op_cnt_q <= op_cnt_d;
      offset_q <= offset_d;
    end
  end
`else
  assign offset      = 2'd0;
  assign rot_trigger = 1'b0;
`endif

  // Sweep/run sequencing: any fault-map change or rotation restarts the sweep at class 0
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    sweep_we = 1'b0;
    case (state_q)
      RUN: begin
        if (fault_changed || rot_trigger) begin
          state_d = SWEEP;
          k_d     = 4'd0;
        end
      end
      SWEEP: begin
        if (fault_changed) begin
          k_d = 4'd0;
        end else begin
          sweep_we = 1'b1;
          if (k_q == 4'(N_CLASS - 1)) begin
            state_d = RUN;
            k_d     = 4'd0;
          end else begin
            k_d = k_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = SWEEP;
        k_d     = 4'd0;
      end
    endcase
  end

  // State, fault-map snapshot, table entries and sticky status
  always_ff @(posedge clock_gated or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SWEEP;
      k_q         <= 4'd0;
      fault_q     <= '0;
      degraded_q  <= '0;
      sched_err_q <= 1'b0;
      for (int c = 0; c < N_CLASS; c++) begin
        table_q[c] <= '0;
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      fault_q <= permanent_faulty_alu_i;
      if (sweep_we) begin
        table_q[k_q]    <= sweep_entry;
        degraded_q[k_q] <= (sweep_entry.mode != TMR);
        if (sweep_entry.mode == NONE) sched_err_q <= 1'b1;
      end
    end
  end

endmodule
